// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared Gray/binary helpers for counters and the async FIFO.
//                Functions operate on a 32-bit word; callers zero-extend
//                narrower values in and truncate the result back out.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    // All-ones value of a w-bit counter (2^w - 1)
    function automatic gray_word_t max_val(input int w);
        if (w >= GRAY_MAX_WIDTH) begin
            return '1;
        end
        return (gray_word_t'(1) << w) - gray_word_t'(1);
    endfunction

    // Binary to reflected Gray code
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR from the MSB downwards
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray2bin_comb.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin_comb
//  Description : Combinational Gray-to-binary converter. Each binary bit is
//                the XOR reduction of the Gray bits at and above it, which
//                avoids a bit-serial chain through a single vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_prefix
            assign bin[i] = ^gray[WIDTH-1:i];
        end
    endgenerate

endmodule : gray2bin_comb
`default_nettype wire

// File: rtl/gray_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_updown_counter
//  Description : Up/down counter with registered binary and Gray outputs,
//                binary or Gray load, wrap or saturate at the limits and a
//                one-cycle wrap/blocked strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit WRAP_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_q,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;
    logic             at_top;
    logic             at_bottom;

    gray2bin_comb #(
        .WIDTH (WIDTH)
    ) u_load_g2b (
        .gray (load_val),
        .bin  (load_bin)
    );

    assign at_top    = (bin_q == MAX_COUNT);
    assign at_bottom = (bin_q == '0);

    // Next-state select: load beats a step; a step at a limit either wraps
    // through the carry/borrow or is held, and in both cases raises wrap.
    always_comb begin
        next_bin  = bin_q;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_gray ? load_bin : load_val;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    next_wrap = 1'b1;
                    next_bin  = WRAP_MODE ? '0 : MAX_COUNT;
                end else begin
                    next_bin = bin_q + WIDTH'(1);
                end
            end else begin
                if (at_bottom) begin
                    next_wrap = 1'b1;
                    next_bin  = WRAP_MODE ? MAX_COUNT : '0;
                end else begin
                    next_bin = bin_q - WIDTH'(1);
                end
            end
        end
    end

    // Binary, Gray and wrap registers update together so the two count
    // forms are never seen out of step.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap   <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= WIDTH'(bin2gray(gray_word_t'(next_bin)));
            wrap   <= next_wrap;
        end
    end

    // Limit flag follows the live direction input against the registered count
    assign at_limit = up ? at_top : at_bottom;

endmodule : gray_updown_counter
`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_updown_counter
//  Description : Self-checking bench: vector table for the 4-bit wrapping
//                counter, a directed sequence for the 4-bit saturating
//                counter and a modelled random run on an 8-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic       load_gray = 1'b0;
    logic [3:0] lv4 = '0;
    logic [7:0] lv8 = '0;

    logic [3:0] w_gray, w_bin, s_gray, s_bin;
    logic       w_wrap, w_lim, s_wrap, s_lim;
    logic [7:0] r_gray, r_bin;
    logic       r_wrap, r_lim;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(4), .WRAP_MODE(1'b1)) u_wrap4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(lv4),
        .gray_q(w_gray), .bin_q(w_bin), .wrap(w_wrap), .at_limit(w_lim)
    );

    gray_updown_counter #(.WIDTH(4), .WRAP_MODE(1'b0)) u_sat4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(lv4),
        .gray_q(s_gray), .bin_q(s_bin), .wrap(s_wrap), .at_limit(s_lim)
    );

    gray_updown_counter #(.WIDTH(8), .WRAP_MODE(1'b1)) u_rand8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(lv8),
        .gray_q(r_gray), .bin_q(r_bin), .wrap(r_wrap), .at_limit(r_lim)
    );

    typedef struct {
        string      name;
        logic       rst, en, up, ld, lg;
        logic [3:0] lv;
        logic [3:0] eb, eg;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic e, logic u, logic l,
                                logic g, logic [3:0] v, logic [3:0] b,
                                logic [3:0] gy, logic w);
        vec_t t;
        t.name = n; t.rst = r; t.en = e; t.up = u; t.ld = l; t.lg = g;
        t.lv = v; t.eb = b; t.eg = gy; t.ew = w;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge, leave them applied and
    // return 1 time unit after the edge for sampling.
    task automatic drive(logic r, logic e, logic u, logic l, logic g,
                         logic [3:0] v4, logic [7:0] v8);
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_gray = g; lv4 = v4; lv8 = v8;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] g2b8(logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [3:0] gray4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        logic [7:0] m, pg, eg8;
        logic       ew8, step;
        logic       e, u, l, g;
        logic [7:0] v;

        // ---------------- wrap-mode table ----------------
        vecs.push_back(mk("rst_a",   1, 0, 0, 0, 0, 4'd0, 4'd0,  4'b0000, 0));
        vecs.push_back(mk("rst_b",   1, 0, 0, 0, 0, 4'd0, 4'd0,  4'b0000, 0));
        for (int i = 1; i < 16; i++)
            vecs.push_back(mk("count_up", 0, 1, 1, 0, 0, 4'd0, 4'(i), gray4[i], 0));
        vecs.push_back(mk("wrap_up", 0, 1, 1, 0, 0, 4'd0, 4'd0,  4'b0000, 1));
        vecs.push_back(mk("hold",    0, 0, 1, 0, 0, 4'd0, 4'd0,  4'b0000, 0));
        vecs.push_back(mk("wrap_dn", 0, 1, 0, 0, 0, 4'd0, 4'd15, 4'b1000, 1));
        vecs.push_back(mk("down",    0, 1, 0, 0, 0, 4'd0, 4'd14, 4'b1001, 0));
        vecs.push_back(mk("dir_up",  0, 1, 1, 0, 0, 4'd0, 4'd15, 4'b1000, 0));
        vecs.push_back(mk("ld_gray", 0, 0, 0, 1, 1, 4'b1101, 4'd9, 4'b1101, 0));
        vecs.push_back(mk("ld_bin",  0, 0, 0, 1, 0, 4'd6, 4'd6,  4'b0101, 0));
        vecs.push_back(mk("ld_en",   0, 1, 1, 1, 0, 4'd3, 4'd3,  4'b0010, 0));
        vecs.push_back(mk("ld_top",  0, 1, 0, 1, 0, 4'd15, 4'd15, 4'b1000, 0));
        vecs.push_back(mk("rst_ld",  1, 1, 1, 1, 0, 4'd7, 4'd0,  4'b0000, 0));
        vecs.push_back(mk("rst_dn",  0, 1, 0, 0, 0, 4'd0, 4'd15, 4'b1000, 1));

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].en, vecs[k].up, vecs[k].ld, vecs[k].lg,
                  vecs[k].lv, 8'd0);
            chk({vecs[k].name, "_bin"},  32'(w_bin),  32'(vecs[k].eb));
            chk({vecs[k].name, "_gray"}, 32'(w_gray), 32'(vecs[k].eg));
            chk({vecs[k].name, "_wrap"}, 32'(w_wrap), 32'(vecs[k].ew));
            chk({vecs[k].name, "_lim"},  32'(w_lim),
                32'(vecs[k].up ? (vecs[k].eb == 4'd15) : (vecs[k].eb == 4'd0)));
        end

        // ---------------- saturating sequence ----------------
        drive(1, 0, 1, 0, 0, 4'd0, 8'd0);
        chk("sat_rst_bin", 32'(s_bin), 0);
        chk("sat_rst_lim_up", 32'(s_lim), 0);
        drive(0, 0, 1, 1, 0, 4'd13, 8'd0);
        chk("sat_ld13", 32'(s_bin), 13);
        drive(0, 1, 1, 0, 0, 4'd0, 8'd0);
        chk("sat_14", 32'(s_bin), 14);
        drive(0, 1, 1, 0, 0, 4'd0, 8'd0);
        chk("sat_15", 32'(s_bin), 15);
        chk("sat_15_wrap", 32'(s_wrap), 0);
        chk("sat_15_lim", 32'(s_lim), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 4'd0, 8'd0);
            chk("sat_hold_bin", 32'(s_bin), 15);
            chk("sat_hold_gray", 32'(s_gray), 32'h8);
            chk("sat_hold_wrap", 32'(s_wrap), 1);
        end
        drive(0, 1, 0, 0, 0, 4'd0, 8'd0);
        chk("sat_dn_bin", 32'(s_bin), 14);
        chk("sat_dn_wrap", 32'(s_wrap), 0);
        chk("sat_dn_lim", 32'(s_lim), 0);
        drive(0, 0, 0, 1, 0, 4'd0, 8'd0);
        chk("sat_ld0", 32'(s_bin), 0);
        chk("sat_ld0_lim_dn", 32'(s_lim), 1);
        drive(0, 1, 0, 0, 0, 4'd0, 8'd0);
        chk("sat_floor_bin", 32'(s_bin), 0);
        chk("sat_floor_wrap", 32'(s_wrap), 1);
        drive(0, 0, 0, 0, 0, 4'd0, 8'd0);
        chk("sat_idle_wrap", 32'(s_wrap), 0);

        // ---------------- 8-bit random run against a model ----------------
        drive(1, 0, 0, 0, 0, 4'd0, 8'd0);
        chk("r8_rst_bin", 32'(r_bin), 0);
        m = 8'd0;
        for (int c = 0; c < 2000; c++) begin
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 4) != 0) ^ (c >= 1000);
            l = ($urandom_range(0, 15) == 0);
            g = 1'($urandom_range(0, 1));
            v = 8'($urandom_range(0, 255));
            if (c % 300 == 7) begin
                l = 1'b1; g = 1'b0; v = u ? 8'd253 : 8'd2;
            end
            pg   = m ^ (m >> 1);
            ew8  = 1'b0;
            step = e && !l;
            if (l) begin
                m = g ? g2b8(v) : v;
            end else if (e) begin
                if (u) begin
                    ew8 = (m == 8'd255);
                    m   = m + 8'd1;
                end else begin
                    ew8 = (m == 8'd0);
                    m   = m - 8'd1;
                end
            end
            eg8 = m ^ (m >> 1);
            drive(0, e, u, l, g, 4'd0, v);
            chk("r8_bin", 32'(r_bin), 32'(m));
            chk("r8_gray", 32'(r_gray), 32'(eg8));
            chk("r8_wrap", 32'(r_wrap), 32'(ew8));
            if (step)
                chk("r8_hamming", $countones(r_gray ^ pg), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gray_updown_counter
`default_nettype wire
